// File: rtl/icache_refill.sv
// icache_refill: miss refill engine (4-word line fetch, tag/data write, replay
// pulse) plus a whole-cache invalidate sweep.
module icache_refill #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned N_WAY      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cache_miss,
  input  logic [31:0]           i_addr_miss,
  input  logic [N_WAY-1:0]      i_vic_miss,
  output logic                  o_resp_miss,
  output logic                  o_mem_req,
  output logic [31:0]           o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_tag_wren,
  output logic [ADDR_WIDTH-1:0] o_tag_wr_addr,
  output logic [N_WAY-1:0]      o_tag_wr_way,
  output logic [TAG_WIDTH-1:0]  o_tag_wdata,
  output logic [DATA_WIDTH-1:0] o_data_wdata,
  input  logic                  i_flush,
  output logic                  o_flush_done,
  output logic                  o_busy
);

  localparam int unsigned WORDS = DATA_WIDTH / 32;
  localparam logic [2:0] CNT_MAX = 3'd4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [2:0]            issue_cnt_q, issue_cnt_d;
  logic [2:0]            rsp_cnt_q, rsp_cnt_d;
  logic                  miss_pend_q, miss_pend_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [31:0]           addr_q, addr_d;
  logic [N_WAY-1:0]      vic_q, vic_d;
  logic [N_WAY-1:0]      rr_q, rr_d;
  logic [DATA_WIDTH-1:0] line_buf_q, line_buf_d;
  logic [ADDR_WIDTH-1:0] flush_idx_q, flush_idx_d;

  logic                  resp_miss_q, resp_miss_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  tag_wren_q, tag_wren_d;
  logic [ADDR_WIDTH-1:0] tag_wr_addr_q, tag_wr_addr_d;
  logic [N_WAY-1:0]      tag_wr_way_q, tag_wr_way_d;
  logic [TAG_WIDTH-1:0]  tag_wdata_q, tag_wdata_d;
  logic [DATA_WIDTH-1:0] data_wdata_q, data_wdata_d;
  logic                  flush_done_q, flush_done_d;
  logic                  busy_q, busy_d;

  // Requested victim is honoured only when exactly one way is named.
  logic                  vic_onehot_c;
  logic [N_WAY-1:0]      victim_c;
  assign vic_onehot_c = (vic_q != '0) && ((vic_q & (vic_q - N_WAY'(1))) == '0);
  assign victim_c     = vic_onehot_c ? vic_q : rr_q;

  // Next-state, pending bits, line capture and registered-output values.
  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    rsp_cnt_d     = rsp_cnt_q;
    miss_pend_d   = miss_pend_q;
    flush_pend_d  = flush_pend_q;
    addr_d        = addr_q;
    vic_d         = vic_q;
    rr_d          = rr_q;
    line_buf_d    = line_buf_q;
    flush_idx_d   = flush_idx_q;
    resp_miss_d   = 1'b0;
    mem_req_d     = 1'b0;
    mem_addr_d    = '0;
    tag_wren_d    = 1'b0;
    tag_wr_addr_d = '0;
    tag_wr_way_d  = '0;
    tag_wdata_d   = '0;
    data_wdata_d  = '0;
    flush_done_d  = 1'b0;
    busy_d        = 1'b0;

    if (i_cache_miss) begin
      miss_pend_d = 1'b1;
      addr_d      = i_addr_miss;
      vic_d       = i_vic_miss;
    end
    if (i_flush) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (miss_pend_q || i_cache_miss) begin
          state_d = S_REQ;
        end else if (flush_pend_q || i_flush) begin
          state_d = S_FLUSH;
        end
      end
      S_REQ, S_WAIT: begin
        if ((state_q == S_REQ) && i_mem_gnt && (issue_cnt_q < CNT_MAX)) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
        end
        if (i_mem_rvalid && (rsp_cnt_q < CNT_MAX)) begin
          for (int unsigned w = 0; w < WORDS; w++) begin
            if (rsp_cnt_q[1:0] == 2'(w)) begin
              line_buf_d[32*w +: 32] = i_mem_rdata;
            end
          end
          rsp_cnt_d = rsp_cnt_q + 3'd1;
        end
        if (rsp_cnt_d == CNT_MAX) begin
          state_d = S_WRITE;
        end else if ((state_q == S_REQ) && (issue_cnt_d == CNT_MAX)) begin
          state_d = S_WAIT;
        end
      end
      S_WRITE: begin
        issue_cnt_d = '0;
        rsp_cnt_d   = '0;
        if (!vic_onehot_c) begin
          rr_d = {rr_q[N_WAY-2:0], rr_q[N_WAY-1]};
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (!i_cache_miss) begin
          miss_pend_d = 1'b0;
        end
        // A flush queued behind the refill starts right after the replay pulse.
        state_d = (flush_pend_q || i_flush) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        flush_idx_d = flush_idx_q + ADDR_WIDTH'(1);
        if (flush_idx_q == '1) begin
          flush_pend_d = 1'b0;
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    resp_miss_d = (state_d == S_RESP);
    mem_req_d   = (state_d == S_REQ);
    if (mem_req_d) begin
      mem_addr_d = {addr_d[31:2], issue_cnt_d[1:0]};
    end
    if (state_d == S_WRITE) begin
      tag_wren_d    = 1'b1;
      tag_wr_addr_d = addr_q[2 +: ADDR_WIDTH];
      tag_wr_way_d  = victim_c;
      tag_wdata_d   = {1'b1, addr_q[2+ADDR_WIDTH +: TAG_WIDTH-1]};
      data_wdata_d  = line_buf_d;
    end else if (state_d == S_FLUSH) begin
      tag_wren_d    = 1'b1;
      tag_wr_addr_d = flush_idx_d;
      tag_wr_way_d  = '1;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      issue_cnt_q   <= '0;
      rsp_cnt_q     <= '0;
      miss_pend_q   <= 1'b0;
      flush_pend_q  <= 1'b0;
      addr_q        <= '0;
      vic_q         <= '0;
      rr_q          <= N_WAY'(1);
      line_buf_q    <= '0;
      flush_idx_q   <= '0;
      resp_miss_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      tag_wren_q    <= 1'b0;
      tag_wr_addr_q <= '0;
      tag_wr_way_q  <= '0;
      tag_wdata_q   <= '0;
      data_wdata_q  <= '0;
      flush_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      rsp_cnt_q     <= rsp_cnt_d;
      miss_pend_q   <= miss_pend_d;
      flush_pend_q  <= flush_pend_d;
      addr_q        <= addr_d;
      vic_q         <= vic_d;
      rr_q          <= rr_d;
      line_buf_q    <= line_buf_d;
      flush_idx_q   <= flush_idx_d;
      resp_miss_q   <= resp_miss_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      tag_wren_q    <= tag_wren_d;
      tag_wr_addr_q <= tag_wr_addr_d;
      tag_wr_way_q  <= tag_wr_way_d;
      tag_wdata_q   <= tag_wdata_d;
      data_wdata_q  <= data_wdata_d;
      flush_done_q  <= flush_done_d;
      busy_q        <= busy_d;
    end
  end

  assign o_resp_miss   = resp_miss_q;
  assign o_mem_req     = mem_req_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_tag_wren    = tag_wren_q;
  assign o_tag_wr_addr = tag_wr_addr_q;
  assign o_tag_wr_way  = tag_wr_way_q;
  assign o_tag_wdata   = tag_wdata_q;
  assign o_data_wdata  = data_wdata_q;
  assign o_flush_done  = flush_done_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: stimulus pushes expected writes, replay
// pulses, flush completions and bus addresses; monitor threads pop and compare.
module tb_icache_refill;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_cache_miss;
  logic [31:0]  i_addr_miss;
  logic [3:0]   i_vic_miss;
  logic         o_resp_miss;
  logic         o_mem_req;
  logic [31:0]  o_mem_addr;
  logic         i_mem_gnt;
  logic         i_mem_rvalid;
  logic [31:0]  i_mem_rdata;
  logic         o_tag_wren;
  logic [5:0]   o_tag_wr_addr;
  logic [3:0]   o_tag_wr_way;
  logic [7:0]   o_tag_wdata;
  logic [127:0] o_data_wdata;
  logic         i_flush;
  logic         o_flush_done;
  logic         o_busy;

  icache_refill dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cache_miss(i_cache_miss), .i_addr_miss(i_addr_miss), .i_vic_miss(i_vic_miss),
    .o_resp_miss(o_resp_miss),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_tag_wren(o_tag_wren), .o_tag_wr_addr(o_tag_wr_addr), .o_tag_wr_way(o_tag_wr_way),
    .o_tag_wdata(o_tag_wdata), .o_data_wdata(o_data_wdata),
    .i_flush(i_flush), .o_flush_done(o_flush_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]   set;
    logic [3:0]   way;
    logic [7:0]   tag;
    logic [127:0] data;
    int           cyc;
  } wr_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  wr_t         exp_wr[$];
  int          exp_resp[$];
  int          exp_done[$];
  logic [31:0] exp_maddr[$];
  rsp_t        rq[$];

  int checks = 0;
  int failures = 0;

  int gnt_stall = 0;
  int rv_delay = 1;
  int rv_limit = 1000000;
  int rv_sent = 0;
  bit plain_mode = 1'b1;
  bit req_dropped = 1'b0;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (plain_mode) return 32'hA0 + {30'd0, a[1:0]};
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic wr_t mk_wr(input logic [31:0] addr, input logic [3:0] way, input int c);
    wr_t w;
    logic [31:0] wa;
    w.set = addr[7:2];
    w.way = way;
    w.tag = {1'b1, addr[14:8]};
    w.cyc = c;
    w.data = '0;
    for (int k = 0; k < 4; k++) begin
      wa = {addr[31:2], 2'(k)};
      w.data[32*k +: 32] = rdata_of(wa);
    end
    return w;
  endfunction

  task automatic push_miss(input logic [31:0] addr, input logic [3:0] way, input int tbase);
    for (int k = 0; k < 4; k++) exp_maddr.push_back({addr[31:2], 2'(k)});
    exp_wr.push_back(mk_wr(addr, way, (tbase < 0) ? -1 : tbase + 6));
    exp_resp.push_back((tbase < 0) ? -1 : tbase + 7);
  endtask

  task automatic push_flush(input int f);
    wr_t w;
    for (int i = 0; i < 64; i++) begin
      w.set = 6'(i); w.way = 4'b1111; w.tag = 8'h00; w.data = '0; w.cyc = f + i;
      exp_wr.push_back(w);
    end
    exp_done.push_back(f + 64);
  endtask

  // Must be called right after a negedge; tbase is the cycle the miss counts from.
  task automatic miss_now(input logic [31:0] addr, input logic [3:0] vic,
                          input logic [3:0] way, input int tbase);
    push_miss(addr, way, tbase);
    i_cache_miss = 1'b1; i_addr_miss = addr; i_vic_miss = vic;
    @(negedge clk);
    i_cache_miss = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (o_resp_miss || o_mem_req || o_tag_wren || o_flush_done || o_busy ||
        o_mem_addr != '0 || o_tag_wr_addr != '0 || o_tag_wr_way != '0 ||
        o_tag_wdata != '0 || o_data_wdata != '0) begin
      failures++;
      $display("FAIL %s: outputs not all zero (req=%b wren=%b resp=%b busy=%b addr=%h)",
               name, o_mem_req, o_tag_wren, o_resp_miss, o_busy, o_mem_addr);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_resp.size() != 0 || exp_done.size() != 0 ||
            exp_maddr.size() != 0 || o_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s timeout: pending wr=%0d resp=%0d done=%0d maddr=%0d busy=%b",
               name, exp_wr.size(), exp_resp.size(), exp_done.size(), exp_maddr.size(), o_busy);
      exp_wr.delete(); exp_resp.delete(); exp_done.delete(); exp_maddr.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: every write, replay pulse and flush completion is matched in order.
  task automatic run_monitor();
    wr_t e;
    int  c;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (o_tag_wren) begin
          checks++;
          if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL write unexpected: set=%h way=%b tag=%h cyc=%0d",
                     o_tag_wr_addr, o_tag_wr_way, o_tag_wdata, cyc);
          end else begin
            e = exp_wr.pop_front();
            if (o_tag_wr_addr !== e.set || o_tag_wr_way !== e.way || o_tag_wdata !== e.tag ||
                o_data_wdata !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
              failures++;
              $display("FAIL write: got set=%h way=%b tag=%h data=%h cyc=%0d exp set=%h way=%b tag=%h data=%h cyc=%0d",
                       o_tag_wr_addr, o_tag_wr_way, o_tag_wdata, o_data_wdata, cyc,
                       e.set, e.way, e.tag, e.data, e.cyc);
            end
          end
        end
        if (o_resp_miss) begin
          checks++;
          if (exp_resp.size() == 0) begin
            failures++;
            $display("FAIL resp unexpected at cyc=%0d", cyc);
          end else begin
            c = exp_resp.pop_front();
            if (c >= 0 && c != cyc) begin
              failures++;
              $display("FAIL resp timing: got cyc=%0d exp cyc=%0d", cyc, c);
            end
          end
        end
        if (o_flush_done) begin
          checks++;
          if (exp_done.size() == 0) begin
            failures++;
            $display("FAIL flush_done unexpected at cyc=%0d", cyc);
          end else begin
            c = exp_done.pop_front();
            if (c != cyc) begin
              failures++;
              $display("FAIL flush_done timing: got cyc=%0d exp cyc=%0d", cyc, c);
            end
          end
        end
      end
    end
  endtask

  // Memory model: configurable grant stall and in-order read latency.
  task automatic run_memory();
    int   stall = 0;
    int   granted = 0;
    bit   active = 1'b0;
    rsp_t r;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
      if (i_rst) begin
        stall = 0; granted = 0; active = 1'b0;
      end else begin
        if (o_mem_req) begin
          active = 1'b1;
          if (stall < gnt_stall) begin
            stall++;
          end else begin
            stall = 0;
            i_mem_gnt = 1'b1;
            checks++;
            if (exp_maddr.size() == 0) begin
              failures++;
              $display("FAIL mem_addr unexpected request addr=%h", o_mem_addr);
            end else begin
              ea = exp_maddr.pop_front();
              if (o_mem_addr !== ea) begin
                failures++;
                $display("FAIL mem_addr: got %h exp %h", o_mem_addr, ea);
              end
            end
            r.due = cyc + rv_delay; r.data = rdata_of(o_mem_addr);
            rq.push_back(r);
            granted++;
            if (granted == 4) begin granted = 0; active = 1'b0; end
          end
        end else if (active) begin
          req_dropped = 1'b1;
        end
      end
      if (rq.size() != 0 && rv_sent < rv_limit) begin
        if (rq[0].due <= cyc) begin
          r = rq.pop_front();
          i_mem_rvalid = 1'b1; i_mem_rdata = r.data;
          rv_sent++;
        end
      end
    end
  endtask

  initial begin
    int t;
    int f;
    int n;
    wr_t w;
    i_rst = 1'b1; i_cache_miss = 1'b0; i_addr_miss = '0; i_vic_miss = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_flush = 1'b0;
    fork
      run_monitor();
      run_memory();
    join_none
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single zero-wait miss with hand-computed line.
    plain_mode = 1'b1; gnt_stall = 0; rv_delay = 1;
    @(negedge clk);
    t = cyc;
    for (int k = 0; k < 4; k++) exp_maddr.push_back(32'h0000_1234 + 32'(k));
    w.set = 6'h0D; w.way = 4'b0100; w.tag = 8'h92;
    w.data = 128'h000000A3_000000A2_000000A1_000000A0; w.cyc = t + 6;
    exp_wr.push_back(w);
    exp_resp.push_back(t + 7);
    i_cache_miss = 1'b1; i_addr_miss = 32'h0000_1235; i_vic_miss = 4'b0100;
    @(negedge clk);
    i_cache_miss = 1'b0;
    wait_idle("single_miss", 100);

    // Stalled bus: same line, req must hold until the fourth grant.
    gnt_stall = 3; rv_delay = 2; req_dropped = 1'b0;
    @(negedge clk);
    miss_now(32'h0000_1235, 4'b0100, 4'b0100, -1);
    wait_idle("stalled_miss", 200);
    checks++;
    if (req_dropped) begin
      failures++;
      $display("FAIL stalled_req_hold: req dropped=1 exp 0");
    end

    // Victim fallback through the round-robin pointer.
    plain_mode = 1'b0; gnt_stall = 0; rv_delay = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      miss_now(32'h0000_4100 + 32'(i * 32'h104), 4'b0000, 4'(1 << i), cyc);
      wait_idle("victim_rr", 100);
    end

    // Flush sweep with a miss injected at sweep index 10.
    @(negedge clk);
    f = cyc + 1;
    push_flush(f);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    repeat (10) @(negedge clk);
    miss_now(32'h0001_2F3C, 4'b1000, 4'b1000, f + 64);
    wait_idle("flush_then_miss", 300);

    // Miss and flush together: refill first, sweep right after the replay pulse.
    @(negedge clk);
    t = cyc;
    push_miss(32'h0000_7777, 4'b0001, t);
    push_flush(t + 8);
    i_cache_miss = 1'b1; i_addr_miss = 32'h0000_7777; i_vic_miss = 4'b0001; i_flush = 1'b1;
    @(negedge clk);
    i_cache_miss = 1'b0; i_flush = 1'b0;
    wait_idle("miss_and_flush", 300);

    // Reset in WAIT after two responses; stale responses afterwards must be ignored.
    @(negedge clk);
    rv_limit = rv_sent + 2;
    for (int k = 0; k < 4; k++) exp_maddr.push_back({30'h0000_0C00 >> 0, 2'(k)});
    i_cache_miss = 1'b1; i_addr_miss = 32'h0000_3000; i_vic_miss = 4'b0010;
    @(negedge clk);
    i_cache_miss = 1'b0;
    n = 0;
    while (rv_sent < rv_limit && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL reset_setup timeout: rv_sent=%0d exp %0d", rv_sent, rv_limit);
    end
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    rv_limit = rv_sent + 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_zero("after_reset");
    end
    rv_limit = 1000000;
    exp_maddr.delete();

    // Fresh refill after reset; non-one-hot victim uses rr from its reset value.
    @(negedge clk);
    miss_now(32'h0000_ABC8, 4'b0011, 4'b0001, cyc);
    wait_idle("post_reset_miss", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
